// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial two's-complement subtractor, LSB first
//
// Computes a_i - b_i one bit per clock through a single full-subtractor cell
// and a borrow flip-flop. An operation takes WIDTH SHIFT cycles after the
// accepting edge; results hold until the next operation completes.
//
// Ports:
//   clk_i    clock, rising edge
//   rst_i    asynchronous active-high reset
//   start_i  request a subtraction (sampled only in IDLE)
//   a_i      minuend, captured on the accepting edge
//   b_i      subtrahend, captured on the accepting edge
//   busy_o   high while shifting
//   done_o   one-cycle strobe; results valid from this cycle
//   diff_o   a - b modulo 2^WIDTH
//   bout_o   final borrow (a < b unsigned)
//   ovf_o    signed overflow of a - b
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             bout_o,
    output logic             ovf_o
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sa_q, sa_d;
    logic [WIDTH-1:0]   sb_q, sb_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic               br_q, br_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;

    logic               d_bit;
    logic               br_nxt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sr_q    <= sr_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sr_d    = sr_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        // Full-subtractor cell on the current LSBs.
        d_bit  = sa_q[0] ^ sb_q[0] ^ br_q;
        br_nxt = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    sa_d    = a_i;
                    sb_d    = b_i;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    // MSBs kept separately since sa/sb are consumed by shifting.
                    a_msb_d = a_i[WIDTH-1];
                    b_msb_d = b_i[WIDTH-1];
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                sr_d  = {d_bit, sr_q[WIDTH-1:1]};
                br_d  = br_nxt;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    diff_d  = sr_d;
                    bout_d  = br_nxt;
                    // The result MSB is this edge's d_bit.
                    ovf_d   = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = (state_q == SHIFT);
    assign done_o = done_q;
    assign diff_o = diff_q;
    assign bout_o = bout_q;
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a, b;
    logic       busy, done, bout, ovf;
    logic [7:0] diff;

    logic       start4;
    logic [3:0] a4, b4;
    logic       busy4, done4, bout4, ovf4;
    logic [3:0] diff4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .a_i(a), .b_i(b),
        .busy_o(busy), .done_o(done), .diff_o(diff), .bout_o(bout), .ovf_o(ovf)
    );

    serial_subtractor #(.WIDTH(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .start_i(start4), .a_i(a4), .b_i(b4),
        .busy_o(busy4), .done_o(done4), .diff_o(diff4), .bout_o(bout4), .ovf_o(ovf4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Transaction-level model: an accepted request produces its result WIDTH
    // edges later; requests arriving while one is pending are dropped.
    logic       m_busy, m_done, m_bout, m_ovf;
    logic [7:0] m_diff;
    logic [7:0] p_diff;
    logic       p_bout, p_ovf;
    int         m_rem;

    function automatic void ref_sub8(input int av, input int bv,
                                     output logic [7:0] rd, output logic rb, output logic ro);
        int sa, sb, sd;
        rd = 8'((av - bv) & 255);
        rb = (av < bv);
        sa = (av >= 128) ? av - 256 : av;
        sb = (bv >= 128) ? bv - 256 : bv;
        sd = sa - sb;
        ro = (sd > 127) || (sd < -128);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_diff = '0; m_bout = 1'b0; m_ovf = 1'b0;
            m_rem  = 0;
        end else begin
            m_done = 1'b0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_busy = 1'b0; m_done = 1'b1;
                    m_diff = p_diff; m_bout = p_bout; m_ovf = p_ovf;
                end
            end else if (start) begin
                ref_sub8(int'(a), int'(b), p_diff, p_bout, p_ovf);
                m_rem  = 8;
                m_busy = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("model_busy", busy, m_busy);
            chk("model_done", done, m_done);
            chk("model_diff", diff, m_diff);
            chk("model_bout", bout, m_bout);
            chk("model_ovf",  ovf,  m_ovf);
        end
    end

    // Pulse start for one cycle, wait (bounded) for done and check literals.
    task automatic run_op(input string name, input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] ed, input logic eb, input logic eo);
        int cnt;
        a = av; b = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 1;
        while (!done && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL %s_timeout actual=no_done required=done", name);
        end else begin
            chk({name, "_latency"}, cnt - 1, 8);
            chk({name, "_diff"}, diff, ed);
            chk({name, "_bout"}, bout, eb);
            chk({name, "_ovf"},  ovf,  eo);
        end
        @(negedge clk);
    endtask

    logic [7:0] pa[5] = '{8'h5A, 8'h00, 8'h80, 8'h7F, 8'h10};
    logic [7:0] pb[5] = '{8'h23, 8'h01, 8'h01, 8'hFF, 8'h01};
    logic [7:0] pd[5] = '{8'h37, 8'hFF, 8'h7F, 8'h80, 8'h0F};
    logic       pbo[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic       pov[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        int cnt, ndone, last, cyc, idx;
        int sa, sb, sd;
        logic [3:0] ed4;
        logic eb4, eo4;

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        start4 = 1'b0; a4 = '0; b4 = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_diff", diff, 0);
        chk("reset_bout", bout, 0);
        chk("reset_ovf",  ovf,  0);
        rst = 1'b0;

        run_op("normal", 8'h5A, 8'h23, 8'h37, 1'b0, 1'b0);
        run_op("borrow", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
        run_op("ovf_neg", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        run_op("ovf_both", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

        // Start while busy is ignored.
        a = 8'h10; b = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        a = 8'hFF; b = 8'h00; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = '0; b = '0;
        ndone = 0;
        for (int i = 0; i < 25; i++) begin
            if (done) begin
                ndone++;
                chk("busy_ignore_diff", diff, 8'h0F);
            end
            @(negedge clk);
        end
        chk("busy_ignore_done_count", ndone, 1);

        // Reset mid-operation.
        a = 8'h7F; b = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_diff", diff, 0);
        chk("midrst_bout", bout, 0);
        chk("midrst_ovf",  ovf,  0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("midrst_no_done", ndone, 0);
        run_op("after_rst", 8'h09, 8'h04, 8'h05, 1'b0, 1'b0);

        // Back-to-back with start held high.
        idx = 0; cyc = 0; last = 0;
        a = pa[0]; b = pb[0]; start = 1'b1;
        while (idx < 5 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                chk("b2b_diff", diff, pd[idx]);
                chk("b2b_bout", bout, pbo[idx]);
                chk("b2b_ovf",  ovf,  pov[idx]);
                if (idx > 0) chk("b2b_period", cyc - last, 9);
                last = cyc;
                idx++;
                if (idx < 5) begin
                    a = pa[idx]; b = pb[idx];
                end else begin
                    start = 1'b0;
                end
            end else if (idx > 0) begin
                chk("b2b_hold", diff, pd[idx-1]);
            end
        end
        start = 1'b0;
        if (idx < 5) begin
            checks++; failures++;
            $display("FAIL b2b_timeout actual=%0d required=5", idx);
        end
        repeat (2) @(negedge clk);

        // Exhaustive WIDTH=4.
        for (int i = 0; i < 256; i++) begin
            a4 = 4'(i >> 4); b4 = 4'(i & 15); start4 = 1'b1;
            @(negedge clk);
            start4 = 1'b0;
            cnt = 0;
            while (!done4 && cnt < 12) begin
                @(negedge clk);
                cnt++;
            end
            ed4 = 4'((int'(a4) - int'(b4)) & 15);
            eb4 = (int'(a4) < int'(b4));
            sa  = (a4 >= 4'd8) ? int'(a4) - 16 : int'(a4);
            sb  = (b4 >= 4'd8) ? int'(b4) - 16 : int'(b4);
            sd  = sa - sb;
            eo4 = (sd > 7) || (sd < -8);
            if (!done4) begin
                checks++; failures++;
                $display("FAIL w4_timeout a=%0h b=%0h actual=no_done required=done", a4, b4);
            end else begin
                chk("w4_latency", cnt, 4);
                chk("w4_diff", diff4, ed4);
                chk("w4_bout", bout4, eb4);
                chk("w4_ovf",  ovf4,  eo4);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
